// File: rtl/mpt_fetch_stage.sv
// mpt_fetch_stage: one stage of the MPT walk pipeline. It takes one
// transaction, reads the MPTE it points at over a single-beat memory port,
// and hands the transaction on. The incoming mpte field holds the address
// of the next MPTE. The outgoing mpte field holds the entry that was read.
// Transactions that need no walk step pass straight through.
//
// Transaction layout (MSB first). MPTE_W = PIPELINE_DATA_WIDTH-16.
//   id[3:0] completed mmpt spa access_type[1:0] rpa valid walking[1:0]
//   plb_hit format_error access_error mpte[MPTE_W-1:0]
//   walking encoding: 0 idle, 1 active, 2 skip, 3 reserved
//
// Ports
//   clk_i, rst_ni                : clock; synchronous active-low reset
//   stage_slave_*                : incoming transaction (valid/ready)
//   stage_master_*               : outgoing transaction (valid/ready)
//   mem_req/addr/we/be           : read request, held until mem_gnt
//   mem_gnt/valid/rdata/error    : grant, response strobe, data, bus error
//   mem_fault_o                  : one-cycle pulse on bus error or timeout
module mpt_fetch_stage #(
  parameter int PIPELINE_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH      = 64,
  parameter int MEM_DATA_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [PIPELINE_DATA_WIDTH-1:0] stage_slave_data,
  input  logic                           stage_slave_valid,
  output logic                           stage_slave_ready,
  output logic [PIPELINE_DATA_WIDTH-1:0] stage_master_data,
  output logic                           stage_master_valid,
  input  logic                           stage_master_ready,
  output logic                           mem_req,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_addr,
  output logic                           mem_we,
  output logic [MEM_DATA_WIDTH/8-1:0]    mem_be,
  input  logic                           mem_gnt,
  input  logic                           mem_valid,
  input  logic [MEM_DATA_WIDTH-1:0]      mem_rdata,
  input  logic                           mem_error,
  output logic                           mem_fault_o
);
  localparam int MPTE_W = PIPELINE_DATA_WIDTH - 16;
  localparam int AE_B   = MPTE_W;
  localparam int WK_LO  = MPTE_W + 3;
  localparam int VLD_B  = MPTE_W + 5;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       WALK_SKIP = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;

  state_e                         state_q, state_d;
  logic [PIPELINE_DATA_WIDTH-1:0] txn_q, txn_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           fault_q, fault_d;

  // Upper rdata bits may be wider than the mpte field.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      txn_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stage_slave_valid) begin
          txn_d = stage_slave_data;
          if (stage_slave_data[VLD_B] && stage_slave_data[WK_LO +: 2] != WALK_SKIP)
            state_d = S_REQ;
          else
            state_d = S_OUT;
        end
      end
      S_REQ: begin
        // A response in the grant cycle counts; before grant it is ignored.
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = mem_valid ? S_OUT : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_valid || cnt_d == TMO) state_d = S_OUT;
      end
      S_OUT: begin
        if (stage_master_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Response / timeout resolution, shared by REQ (grant+valid) and WAIT.
    // A response beats expiry in the same cycle.
    if ((state_q == S_REQ && mem_gnt && mem_valid) || state_q == S_WAIT) begin
      if (mem_valid && !mem_error) begin
        txn_d[MPTE_W-1:0] = MPTE_W'(mem_rdata);
      end else if (mem_valid || (state_q == S_WAIT && cnt_d == TMO)) begin
        txn_d[WK_LO +: 2]  = WALK_SKIP;
        txn_d[AE_B]        = 1'b1;
        txn_d[MPTE_W-1:0]  = '0;
        fault_d            = 1'b1;
      end
    end
  end

  assign stage_slave_ready  = (state_q == S_IDLE);
  assign stage_master_valid = (state_q == S_OUT);
  assign stage_master_data  = txn_q;
  assign mem_req            = (state_q == S_REQ);
  assign mem_addr           = MEM_ADDR_WIDTH'(txn_q[MPTE_W-1:0]);
  assign mem_we             = 1'b0;
  assign mem_be             = '1;
  assign mem_fault_o        = fault_q;
endmodule
